// File: rtl/speech_pkg.sv
// Shared types and constants for the speech capture pipeline.
package speech_pkg;

    // Endpoint detector states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPEECH = 2'd1,
        HANG   = 2'd2,
        DONE   = 2'd3
    } ep_state_t;

    // Offset-binary midpoint; a sample of this value carries no energy
    localparam logic [7:0] SILENCE_LEVEL = 8'd128;

    // Distance of an offset-binary sample from silence, range 0..128
    function automatic logic [7:0] sample_mag(input logic [7:0] s);
        return (s >= SILENCE_LEVEL) ? (s - SILENCE_LEVEL) : (SILENCE_LEVEL - s);
    endfunction

endpackage

// File: rtl/frame_energy_acc.sv
// Per-frame energy: sums |sample - 128| over FRAME_LEN accepted samples and
// publishes the total with a one-cycle frame_valid pulse.
module frame_energy_acc
    import speech_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              accept,        // sample taken this cycle
    input  logic                              clear,         // abandon the frame in progress
    input  logic [7:0]                        sample,
    output logic                              frame_last_c,  // this accepted sample closes a frame
    output logic [8+$clog2(FRAME_LEN)-1:0]    frame_sum_c,   // energy including this sample
    output logic                              frame_valid,
    output logic [8+$clog2(FRAME_LEN)-1:0]    frame_energy
);

    localparam int unsigned POS_W    = $clog2(FRAME_LEN);
    localparam int unsigned ENERGY_W = 8 + POS_W;

    logic [POS_W-1:0]    pos;
    logic [ENERGY_W-1:0] acc;
    logic [7:0]          mag_c;

    assign mag_c        = sample_mag(sample);
    assign frame_last_c = accept && (pos == POS_W'(FRAME_LEN - 1));
    assign frame_sum_c  = acc + ENERGY_W'(mag_c);

    // Accumulator and frame position; a closing sample restarts both so the
    // next frame begins clean in the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos          <= '0;
            acc          <= '0;
            frame_valid  <= 1'b0;
            frame_energy <= '0;
        end else begin
            frame_valid <= frame_last_c;
            if (frame_last_c) begin
                frame_energy <= frame_sum_c;
            end
            if (clear || frame_last_c) begin
                pos <= '0;
                acc <= '0;
            end else if (accept) begin
                pos <= pos + POS_W'(1);
                acc <= frame_sum_c;
            end
        end
    end

endmodule

// File: rtl/utterance_capture.sv
// Energy-threshold endpoint detector that streams utterance samples into an
// external capture RAM and reports the stored length.
module utterance_capture
    import speech_pkg::*;
#(
    parameter int unsigned FRAME_LEN   = 64,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned THRESH      = 1000,
    parameter int unsigned HANG_FRAMES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_valid,
    input  logic [7:0]                     sample,
    input  logic                           done_ack,
    output logic                           mem_wr_en,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [7:0]                     mem_wdata,
    output logic                           frame_valid,
    output logic [8+$clog2(FRAME_LEN)-1:0] frame_energy,
    output logic                           utterance_active,
    output logic                           utterance_done,
    output logic [ADDR_W:0]                utterance_len,
    output logic                           overflow
);

    localparam int unsigned ENERGY_W = 8 + $clog2(FRAME_LEN);
    localparam int unsigned HANG_W   = $clog2(HANG_FRAMES + 1);
    localparam int unsigned LEN_W    = ADDR_W + 1;
    localparam logic [LEN_W-1:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

    ep_state_t           state, state_nxt;
    logic [ADDR_W-1:0]   wr_ptr, wr_ptr_nxt;
    logic [ADDR_W-1:0]   frame_base, frame_base_nxt;
    logic [HANG_W-1:0]   hang_cnt, hang_cnt_nxt;
    logic [LEN_W-1:0]    len_nxt;
    logic                ovf_nxt;
    logic                done_nxt;

    logic                accept_c;
    logic                ack_c;
    logic                full_c;
    logic                speech_c;
    logic                hang_end_c;
    logic                frame_last_c;
    logic [ENERGY_W-1:0] frame_sum_c;
    logic [LEN_W-1:0]    stored_len_c;
    logic [HANG_W-1:0]   hang_inc_c;

    // Samples are dropped while DONE waits for the consumer, including the
    // cycle in which the ack itself arrives.
    assign accept_c     = sample_valid && (state != DONE);
    assign ack_c        = done_ack && (state == DONE);
    assign full_c       = accept_c && ((state == SPEECH) || (state == HANG)) && (wr_ptr == '1);
    assign speech_c     = 32'(frame_sum_c) >= THRESH;
    assign stored_len_c = {1'b0, wr_ptr} + LEN_W'(1);
    assign hang_inc_c   = hang_cnt + HANG_W'(1);
    assign hang_end_c   = hang_inc_c == HANG_W'(HANG_FRAMES);

    frame_energy_acc #(
        .FRAME_LEN (FRAME_LEN)
    ) u_energy (
        .clk          (clk),
        .reset        (reset),
        .accept       (accept_c),
        .clear        (full_c || ack_c),
        .sample       (sample),
        .frame_last_c (frame_last_c),
        .frame_sum_c  (frame_sum_c),
        .frame_valid  (frame_valid),
        .frame_energy (frame_energy)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, pointer updates and result capture
    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        frame_base_nxt = frame_base;
        hang_cnt_nxt   = hang_cnt;
        len_nxt        = utterance_len;
        ovf_nxt        = overflow;
        done_nxt       = 1'b0;

        if (accept_c) begin
            wr_ptr_nxt = wr_ptr + ADDR_W'(1);
        end

        case (state)
            IDLE: begin
                if (frame_last_c) begin
                    if (speech_c) begin
                        state_nxt      = SPEECH;
                        frame_base_nxt = wr_ptr + ADDR_W'(1);
                    end else begin
                        // Pre-roll frame not kept: overwrite it with the next one
                        wr_ptr_nxt = frame_base;
                    end
                end
            end
            SPEECH: begin
                if (full_c) begin
                    state_nxt = DONE;
                    ovf_nxt   = 1'b1;
                    len_nxt   = FULL_LEN;
                    done_nxt  = 1'b1;
                end else if (frame_last_c) begin
                    frame_base_nxt = wr_ptr + ADDR_W'(1);
                    if (!speech_c) begin
                        hang_cnt_nxt = HANG_W'(1);
                        if (HANG_FRAMES == 1) begin
                            state_nxt = DONE;
                            len_nxt   = stored_len_c;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = HANG;
                        end
                    end
                end
            end
            HANG: begin
                if (full_c) begin
                    state_nxt = DONE;
                    ovf_nxt   = 1'b1;
                    len_nxt   = FULL_LEN;
                    done_nxt  = 1'b1;
                end else if (frame_last_c) begin
                    frame_base_nxt = wr_ptr + ADDR_W'(1);
                    if (speech_c) begin
                        state_nxt    = SPEECH;
                        hang_cnt_nxt = '0;
                    end else begin
                        hang_cnt_nxt = hang_inc_c;
                        if (hang_end_c) begin
                            state_nxt = DONE;
                            len_nxt   = stored_len_c;
                            done_nxt  = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                if (ack_c) begin
                    state_nxt      = IDLE;
                    wr_ptr_nxt     = '0;
                    frame_base_nxt = '0;
                    hang_cnt_nxt   = '0;
                    ovf_nxt        = 1'b0;
                    len_nxt        = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pointer registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr           <= '0;
            frame_base       <= '0;
            hang_cnt         <= '0;
            mem_wr_en        <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            utterance_active <= 1'b0;
            utterance_done   <= 1'b0;
            utterance_len    <= '0;
            overflow         <= 1'b0;
        end else begin
            wr_ptr           <= wr_ptr_nxt;
            frame_base       <= frame_base_nxt;
            hang_cnt         <= hang_cnt_nxt;
            mem_wr_en        <= accept_c;
            if (accept_c) begin
                mem_addr  <= wr_ptr;
                mem_wdata <= sample;
            end
            utterance_active <= (state_nxt == SPEECH) || (state_nxt == HANG);
            utterance_done   <= done_nxt;
            utterance_len    <= len_nxt;
            overflow         <= ovf_nxt;
        end
    end

endmodule
